// File: rtl/logic_unit_seq_pkg.sv
// Shared definitions for logic_unit_seq.
// Holds the 4-bit ALUFun op codes (the original five AND/OR/XOR/NOR/MOV keep
// their encodings), the scan FSM state encoding and the is_iterative() helper
// that separates the multi-cycle bit-scan ops from the single-cycle ones.
package logic_unit_seq_pkg;

  // Single-cycle group
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1110;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_NAND = 4'b0111;
  localparam logic [3:0] OP_XNOR = 4'b1001;
  localparam logic [3:0] OP_ANDN = 4'b0100;
  localparam logic [3:0] OP_ORN  = 4'b1101;
  localparam logic [3:0] OP_MOVB = 4'b1100;

  // Iterative group (operand A only)
  localparam logic [3:0] OP_CLZ  = 4'b0010;
  localparam logic [3:0] OP_POPC = 4'b0011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_CLZ) || (op == OP_POPC);
  endfunction

endpackage

// File: rtl/logic_chunk_scan.sv
// Combinational bit-scan of one CHUNK-wide slice.
// Ports:
//   slice_i        in   CHUNK  slice to scan, bit CHUNK-1 is the most significant
//   slice_clz      out  CW     leading zeros from the MSB (CHUNK when all zero)
//   slice_popc     out  CW     number of set bits
//   slice_nonzero  out  1      slice contains at least one set bit
module logic_chunk_scan #(
  parameter int CHUNK = 8,
  parameter int CW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] slice_i,
  output logic [CW-1:0]    slice_clz,
  output logic [CW-1:0]    slice_popc,
  output logic             slice_nonzero
);

  logic seen;

  always_comb begin
    // NOTE: every variable gets a value before any conditional logic so the
    // block stays purely combinational and no latch is inferred.
    slice_clz  = CW'(CHUNK);
    slice_popc = '0;
    seen       = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (slice_i[i]) begin
        slice_popc = slice_popc + CW'(1);
        if (!seen) begin
          slice_clz = CW'(CHUNK - 1 - i);
          seen      = 1'b1;
        end
      end
    end
    slice_nonzero = |slice_i;
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Handshaked logic unit: single-cycle bitwise ops plus multi-cycle CLZ/POPC
// that walk operand A one CHUNK slice per cycle, MSB slice first.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake; in_ready depends only on state and
//                        the output register, never on in_valid
//   in_a, in_b, in_op    operands and ALUFun[3:0] op code
//   out_valid/out_ready  result handshake
//   out_data, out_err    result and illegal-op flag, held while stalled
module logic_unit_seq
  import logic_unit_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = $clog2(CHUNK + 1);
  localparam int ACC_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               popc_q, popc_d;
  logic               clz_done_q, clz_done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_next;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               out_err_q, out_err_d;

  logic [CW-1:0]      slice_clz, slice_popc;
  logic               slice_nonzero;
  logic               out_free, last_slice;

  // The slice under test is always the top CHUNK bits; the shifter moves the
  // next lower slice up each SCAN edge.
  logic_chunk_scan #(.CHUNK(CHUNK), .CW(CW)) u_scan (
    .slice_i       (shift_q[WIDTH-1 -: CHUNK]),
    .slice_clz     (slice_clz),
    .slice_popc    (slice_popc),
    .slice_nonzero (slice_nonzero)
  );

  function automatic logic [WIDTH:0] single_op(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    // Returns {err, data}
    case (op)
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_NOR:  return {1'b0, ~(a | b)};
      OP_MOV:  return {1'b0, a};
      OP_NAND: return {1'b0, ~(a & b)};
      OP_XNOR: return {1'b0, ~(a ^ b)};
      OP_ANDN: return {1'b0, a & ~b};
      OP_ORN:  return {1'b0, a | ~b};
      OP_MOVB: return {1'b0, b};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  assign out_free   = !out_valid_q || out_ready;
  assign in_ready   = (state_q == ST_IDLE) && out_free;
  assign last_slice = (cnt_q == CNT_W'(N - 1));

  // CLZ stops accumulating once a slice with a set bit has been seen.
  always_comb begin
    acc_next = acc_q;
    if (popc_q)           acc_next = acc_q + ACC_W'(slice_popc);
    else if (!clz_done_q) acc_next = acc_q + ACC_W'(slice_clz);
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    popc_d      = popc_q;
    clz_done_d  = clz_done_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;

    // A consumed result clears unless a new one overwrites it below.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (is_iterative(in_op)) begin
            state_d    = ST_SCAN;
            shift_d    = in_a;
            popc_d     = (in_op == OP_POPC);
            clz_done_d = 1'b0;
            cnt_d      = '0;
            acc_d      = '0;
          end else begin
            out_valid_d             = 1'b1;
            {out_err_d, out_data_d} = single_op(in_op, in_a, in_b);
          end
        end
      end
      ST_SCAN: begin
        // The final slice waits, accumulator frozen, for a free output slot.
        if (!last_slice || out_free) begin
          shift_d    = shift_q << CHUNK;
          cnt_d      = cnt_q + CNT_W'(1);
          acc_d      = acc_next;
          clz_done_d = clz_done_q | slice_nonzero;
          if (last_slice) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
            out_data_d  = WIDTH'(acc_next);
            out_err_d   = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // NOTE: scan datapath registers carry no reset; they are always loaded on
  // acceptance before being read, so resetting them would only add logic.
  always_ff @(posedge clk) begin
    shift_q    <= shift_d;
    popc_q     <= popc_d;
    clz_done_q <= clz_done_d;
    acc_q      <= acc_d;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule
